// File: rtl/swi_conditioner_if.sv
// swi_conditioner_if: raw switch input and conditioned outputs of swi_conditioner.
interface swi_conditioner_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] swi_raw;
    logic [NBITS-1:0] swi_clean;
    logic [NBITS-1:0] swi_rise;
    logic [NBITS-1:0] swi_fall;
    logic [NBITS-1:0] swi_toggle;
    logic             swi_changed;
    logic [7:0]       event_cnt;
    modport master (output swi_raw, input swi_clean, swi_rise, swi_fall, swi_toggle, swi_changed, event_cnt);
    modport slave (input swi_raw, output swi_clean, swi_rise, swi_fall, swi_toggle, swi_changed, event_cnt);
endinterface

// File: rtl/swi_conditioner.sv
// swi_conditioner: 2-flop sync + per-bit debounce, rise/fall strobes and change counter.
// Define SWI_CONDITIONER_TOGGLE_EN to build the per-bit push-on/push-off toggle latches.
module swi_conditioner #(
    parameter int NBITS = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic clk_2,
    input logic rst_n,
    swi_conditioner_if.slave bus
);
    typedef enum logic {STABLE, PENDING} state_e;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [NBITS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NBITS-1:0] clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, done;
    logic [CNT_W-1:0] cnt_q [NBITS];
    logic [CNT_W-1:0] cnt_d [NBITS];
    state_e           state [NBITS];
    logic             changed_q, changed_d;
    logic [7:0]       event_cnt_q, event_cnt_d;
    always_comb begin
        sync1_d = bus.swi_raw;
        sync2_d = sync1_q;
        done = '0;
        clean_d = clean_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NBITS; i++) begin
            state[i] = (sync2_q[i] != clean_q[i]) ? PENDING : STABLE;
            done[i] = (state[i] == PENDING) && (cnt_q[i] == LAST);
            cnt_d[i] = (state[i] == PENDING && !done[i]) ? cnt_q[i] + 1'b1 : '0;
            clean_d[i] = done[i] ? sync2_q[i] : clean_q[i];
            rise_d[i] = done[i] & sync2_q[i];
            fall_d[i] = done[i] & ~sync2_q[i];
        end
        changed_d = |(rise_d | fall_d);
        event_cnt_d = event_cnt_q + 8'(changed_d);
    end
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            changed_q <= 1'b0;
            event_cnt_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            changed_q <= changed_d;
            event_cnt_q <= event_cnt_d;
            cnt_q <= cnt_d;
        end
    end
`ifdef SWI_CONDITIONER_TOGGLE_EN
    logic [NBITS-1:0] toggle_q, toggle_d;
    always_comb toggle_d = toggle_q ^ rise_q;
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) toggle_q <= '0;
        else toggle_q <= toggle_d;
    end
    assign bus.swi_toggle = toggle_q;
`else
    assign bus.swi_toggle = '0;
`endif
    assign bus.swi_clean = clean_q;
    assign bus.swi_rise = rise_q;
    assign bus.swi_fall = fall_q;
    assign bus.swi_changed = changed_q;
    assign bus.event_cnt = event_cnt_q;
endmodule

// File: tb/tb_swi_conditioner.sv
// tb_swi_conditioner: directed stimulus with a strobe scoreboard for swi_conditioner (DEBOUNCE_CYCLES=4).
module tb_swi_conditioner;
    typedef struct {
        string      tag;
        int         edge_no;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] clean;
    } exp_t;
    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;
    int   edge_no = 0;
    int   vectors = 0;
    int   errors = 0;
    exp_t sb[$];
    swi_conditioner_if #(.NBITS(8)) bus ();
    swi_conditioner #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (.clk_2(clk_2), .rst_n(rst_n), .bus(bus));
    always #5 clk_2 = ~clk_2;
    always @(posedge clk_2) edge_no++;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk_2);
    endtask
    // A change driven now is captured at the next edge and settles 5 edges after that.
    task automatic expect_change(input string tag, input logic [7:0] rise, input logic [7:0] fall,
                                 input logic [7:0] clean);
        exp_t e;
        e.tag = tag;
        e.edge_no = edge_no + 6;
        e.rise = rise;
        e.fall = fall;
        e.clean = clean;
        sb.push_back(e);
    endtask
    task automatic drive(input string tag, input logic [7:0] raw, input logic [7:0] rise,
                         input logic [7:0] fall, input logic [7:0] clean, input int wait_n);
        bus.swi_raw = raw;
        expect_change(tag, rise, fall, clean);
        tick(wait_n);
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_clean"}, 32'(bus.swi_clean), 0);
        chk({tag, "_rise"}, 32'(bus.swi_rise), 0);
        chk({tag, "_fall"}, 32'(bus.swi_fall), 0);
        chk({tag, "_changed"}, 32'(bus.swi_changed), 0);
        chk({tag, "_cnt"}, 32'(bus.event_cnt), 0);
        chk({tag, "_toggle"}, 32'(bus.swi_toggle), 0);
    endtask
    always @(negedge clk_2) begin
        if (rst_n && bus.swi_changed) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(bus.swi_rise | bus.swi_fall), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_edge"}, 32'(edge_no), 32'(e.edge_no));
                chk({e.tag, "_rise"}, 32'(bus.swi_rise), 32'(e.rise));
                chk({e.tag, "_fall"}, 32'(bus.swi_fall), 32'(e.fall));
                chk({e.tag, "_clean"}, 32'(bus.swi_clean), 32'(e.clean));
            end
        end
    end
    initial begin
        logic [7:0] tog_exp;
        int         mark;
        bus.swi_raw = 8'hFF;
        tick(3);
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        expect_change("post_reset_rise", 8'hFF, 8'h00, 8'hFF);
        tick(10);
        chk("post_reset_cnt", 32'(bus.event_cnt), 1);
        drive("all_fall", 8'h00, 8'h00, 8'hFF, 8'h00, 10);
        drive("rise_81", 8'h81, 8'h81, 8'h00, 8'h81, 10);
        chk("rise_81_cnt", 32'(bus.event_cnt), 3);
        bus.swi_raw = 8'h89;
        tick(3);
        bus.swi_raw = 8'h81;
        tick(10);
        chk("glitch_clean", 32'(bus.swi_clean), 32'h81);
        chk("glitch_cnt", 32'(bus.event_cnt), 3);
        drive("bit0_fall", 8'h80, 8'h00, 8'h01, 8'h80, 10);
        for (int i = 0; i < 4; i++) begin
            bus.swi_raw = (i % 2 == 0) ? 8'h81 : 8'h80;
            tick(1);
        end
        drive("bounce_settle", 8'h81, 8'h01, 8'h00, 8'h81, 10);
        chk("bounce_cnt", 32'(bus.event_cnt), 5);
        bus.swi_raw = 8'hFF;
        tick(2);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        tick(2);
        chk_all_zero("reset_mid_count");
        rst_n = 1'b1;
        expect_change("reset_release_rise", 8'hFF, 8'h00, 8'hFF);
        tick(10);
        drive("all_fall2", 8'h00, 8'h00, 8'hFF, 8'h00, 10);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        chk("wrap_start_cnt", 32'(bus.event_cnt), 0);
        for (int p = 0; p < 256; p++) begin
            mark = edge_no;
            drive("wrap_press", 8'h01, 8'h01, 8'h00, 8'h01, 8);
`ifdef SWI_CONDITIONER_TOGGLE_EN
            tog_exp = (p % 2 == 0) ? 8'h01 : 8'h00;
`else
            tog_exp = 8'h00;
`endif
            if (p % 64 == 0 || p == 255) chk("toggle_after_press", 32'(bus.swi_toggle), 32'(tog_exp));
            if (p == 0) chk("wrap_first_cnt", 32'(bus.event_cnt), 1);
            drive("wrap_release", 8'h00, 8'h00, 8'h01, 8'h00, 8);
            if (edge_no - mark != 16) chk("wrap_step_len", 32'(edge_no - mark), 16);
        end
        chk("wrap_end_cnt", 32'(bus.event_cnt), 0);
        chk("toggle_end", 32'(bus.swi_toggle), 0);
        tick(10);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
